mask_gen: RTL
=============

Name: mask_gen

Overview:
- Upstream producer of the mask stream consumed by the masking stage.
- Takes the DVI pixel stream, computes 8-bit luminance and thresholds it against a frame-latched threshold.
- Cleans the result with a 3-tap horizontal majority filter and emits one mask bit per pixel, with its coordinates, at a fixed 6-cycle latency. The masking stage relies on that fixed latency to pair each mask bit with its delayed pixel.
- Also reports a per-frame count of mask-on pixels.

Parameters:
- H_ACT, 640, active pixels per line; last pixel is X = H_ACT-1.
- V_ACT, 480, active lines per frame; last line is Y = V_ACT-1.
- LAT, 6, fixed pipeline latency in cycles. Not user-changeable; any other value is a synthesis error.

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  reset, asynchronous, active-high
- iDVI_VAL  in  1  pixel valid
- iDVI_X  in  10  pixel column
- iDVI_Y  in  10  pixel row
- iDVI_R  in  8  red
- iDVI_G  in  8  green
- iDVI_B  in  8  blue
- iTHRESH  in  8  luminance threshold, sampled at frame start
- iINVERT  in  1  1 = mask on when luma below threshold; sampled at frame start
- iFILT_EN  in  1  1 = majority filter on; sampled at frame start
- oMASK  out  1  mask bit
- oMASK_VAL  out  1  mask valid
- oMASK_X  out  10  mask column
- oMASK_Y  out  10  mask row
- oCNT  out  20  mask-on count of the last completed frame
- oCNT_VAL  out  1  one-cycle pulse when oCNT updates

Behaviour:
- One clock, iCLK. Reset iRST is asynchronous and active-high.
- While iRST is high, all outputs and all pipeline registers are 0. The latched config resets to iTHRESH=128, iINVERT=0, iFILT_EN=1.
- The pipeline advances every cycle and is never stalled. Valid, X and Y travel with the data, so a pixel presented with iDVI_VAL=1 at cycle n appears with oMASK_VAL=1 at cycle n+6, whatever gaps occur in valid.
- When oMASK_VAL=0, oMASK, oMASK_X and oMASK_Y hold their previous values.
- Stage 1: register the inputs.
- Stage 2: luma = (77*R + 150*G + 29*B) >> 8, computed at 16-bit width. The weights sum to 256, so the result fits 8 bits and saturation is not needed.
- Stage 3: raw = (luma >= thr) XOR inv, using the latched config.
- Stage 4: 3-slot window shift register (left, centre, right) of {valid, raw, X, Y}.
- Stage 5: filtered value for the centre pixel.
  - A neighbour counts as 1 only if it is valid, has the same Y as the centre, and its raw bit is 1.
  - Filtered = majority(left, centre, right).
  - With iFILT_EN=0, filtered = centre raw.
  - An invalid centre produces an invalid output.
- Stage 6: output register.
- Latency bookkeeping: the window centre is taken so that the total is exactly 6 cycles. The window reads the right neighbour one slot ahead of the centre.
- Line boundaries: at X=0 or X=H_ACT-1, the missing or other-row neighbour counts as 0. This means an isolated edge pixel needs both the centre and the in-row neighbour set to be on.
- Config latch: iTHRESH, iINVERT and iFILT_EN are captured on the cycle when iDVI_VAL=1 and X=0 and Y=0. They are applied to that pixel and all later pixels. Mid-frame changes on the inputs have no effect until the next frame start.
- Counter:
  - A 20-bit accumulator increments on every output with oMASK_VAL=1 and oMASK=1.
  - On an output pixel with X=H_ACT-1 and Y=V_ACT-1, oCNT is loaded with the final count, including that pixel, and oCNT_VAL pulses on the next cycle.
  - On that same cycle the accumulator clears to 0.
  - If the frame start of the next frame's output arrives without a preceding frame-end pixel (truncated frame), the accumulator clears and oCNT is not updated.
- Reset mid-frame: the pipeline flushes and no stale valid is emitted after release. The first oCNT_VAL occurs only after a complete frame.

Decomposition:
- Shared package mask_pkg holds:
  - the luma weights (77, 150, 29);
  - LAT = 6;
  - the reset threshold 128;
  - the coordinate width (10) and colour width (8).
- The masking stage imports the same LAT for its pixel delay.
- One natural sub-module: luma_calc (R, G, B -> 8-bit luma, 1 register stage).
- The window, filter, config latch and counter stay in mask_gen.

Test Plan:
- Config latched at frame start: iTHRESH=100. Pixel R=G=B=100 at (0,0) -> oMASK_VAL=1, oMASK=1, X=0, Y=0 exactly 6 cycles later. Pixel R=G=B=99 -> oMASK=0. With iINVERT=1 both results flip.
- Fixed latency with gaps: valid pixels with 0, 1 and 3 idle cycles between them -> each output appears exactly 6 cycles after its input, and X/Y are preserved.
- Majority filter: a line with raw pattern 0,1,0,1,1,0 -> filtered 0,0,1,1,1,0. With iFILT_EN=0 the output is the raw pattern.
- Line boundary: last pixel of row 5 raw 1 and first pixel of row 6 raw 1, with their in-row neighbours 0 -> both outputs 0. Mid-frame change of iTHRESH is ignored until the next (0,0).
- Frame count: H_ACT=4, V_ACT=2 build with 5 mask-on pixels -> oCNT=5 with a one-cycle oCNT_VAL after the (3,1) output. The next frame's all-off pixels -> oCNT=0.
- Reset mid-frame: assert iRST during row 0 -> all outputs 0 immediately, with no clock edge needed. After release, no oMASK_VAL until new input, and no oCNT_VAL until a full frame completes.

Source files
------------

// File: rtl/mask_pkg.sv
// Shared constants and payload types for the mask generator and the masking stage.
// The masking stage takes its pixel delay from LAT.
package mask_pkg;

   localparam int unsigned LAT    = 6;
   localparam int unsigned CW     = 10;
   localparam int unsigned PW     = 8;
   localparam int unsigned CNT_W  = 20;
   localparam int unsigned LUMA_W = 16;

   localparam logic [PW-1:0] W_R     = 8'd77;
   localparam logic [PW-1:0] W_G     = 8'd150;
   localparam logic [PW-1:0] W_B     = 8'd29;
   localparam logic [PW-1:0] THR_RST = 8'd128;

   typedef struct packed {
      logic [PW-1:0] thr;
      logic          inv;
      logic          filt;
   } cfg_t;

   localparam cfg_t CFG_RST = '{thr: THR_RST, inv: 1'b0, filt: 1'b1};

   // Pixel travelling through stages 1-2, carrying its own sampled config.
   typedef struct packed {
      logic          val;
      logic          sof;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      cfg_t          cfg;
   } pix_t;

   // Window slot holding a thresholded pixel.
   typedef struct packed {
      logic          val;
      logic          raw;
      logic          filt;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } win_t;

   // Left neighbour needs only what the vote uses.
   typedef struct packed {
      logic          val;
      logic          raw;
      logic [CW-1:0] y;
   } nb_t;

   typedef struct packed {
      logic          val;
      logic          mask;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } out_t;

endpackage

// File: rtl/mask_gen_luma_calc.sv
// Weighted RGB to 8-bit luminance, one register stage.
module luma_calc
   import mask_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [PW-1:0] r,
   input  logic [PW-1:0] g,
   input  logic [PW-1:0] b,
   output logic [PW-1:0] luma
);

   logic [LUMA_W-1:0] sum_c;

   // Weights total 256, so the upper byte is the exact luma.
   always_comb begin
      sum_c = LUMA_W'(W_R) * LUMA_W'(r)
            + LUMA_W'(W_G) * LUMA_W'(g)
            + LUMA_W'(W_B) * LUMA_W'(b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) luma <= '0;
      else     luma <= sum_c[LUMA_W-1:PW];
   end

endmodule

// File: rtl/mask_gen.sv
// Luma threshold mask with 3-tap horizontal majority clean-up, fixed 6-cycle latency,
// plus a per-frame count of mask-on pixels.
module mask_gen
   import mask_pkg::*;
#(
   parameter int unsigned H_ACT = 640,
   parameter int unsigned V_ACT = 480
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iDVI_VAL,
   input  logic [CW-1:0]    iDVI_X,
   input  logic [CW-1:0]    iDVI_Y,
   input  logic [PW-1:0]    iDVI_R,
   input  logic [PW-1:0]    iDVI_G,
   input  logic [PW-1:0]    iDVI_B,
   input  logic [PW-1:0]    iTHRESH,
   input  logic             iINVERT,
   input  logic             iFILT_EN,
   output logic             oMASK,
   output logic             oMASK_VAL,
   output logic [CW-1:0]    oMASK_X,
   output logic [CW-1:0]    oMASK_Y,
   output logic [CNT_W-1:0] oCNT,
   output logic             oCNT_VAL
);

   localparam int unsigned   STAGES = 6;
   localparam logic [CW-1:0] X_LAST = CW'(H_ACT - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(V_ACT - 1);

   if (STAGES != LAT) begin : g_lat_check
      $error("mask_gen: pipeline depth differs from LAT");
   end

   pix_t          in_c, s1, s2;
   logic [PW-1:0] s1_r, s1_g, s1_b, s2_luma;
   cfg_t          cfg_q, cfg_c;
   win_t          r3_c, r3, w_c;
   nb_t           w_l;
   logic          nb_l_c, nb_r_c, filt_c;
   out_t          f5;
   logic          sof_out_c, eof_out_c;
   logic [CNT_W-1:0] acc;
   logic          started;

   always_comb begin
      in_c     = '0;
      in_c.val = iDVI_VAL;
      in_c.sof = iDVI_VAL && (iDVI_X == '0) && (iDVI_Y == '0);
      in_c.x   = iDVI_X;
      in_c.y   = iDVI_Y;
      in_c.cfg = '{thr: iTHRESH, inv: iINVERT, filt: iFILT_EN};
   end

   // Stages 1-2: input register, then luma alongside the delayed pixel info.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         s1   <= '0;
         s1_r <= '0;
         s1_g <= '0;
         s1_b <= '0;
         s2   <= '0;
      end else begin
         s1   <= in_c;
         s1_r <= iDVI_R;
         s1_g <= iDVI_G;
         s1_b <= iDVI_B;
         s2   <= s1;
      end
   end

   luma_calc u_luma (
      .clk  (iCLK),
      .rst  (iRST),
      .r    (s1_r),
      .g    (s1_g),
      .b    (s1_b),
      .luma (s2_luma)
   );

   // Frame-start pixel brings its own config so earlier in-flight pixels keep the old one.
   always_comb begin
      cfg_c = cfg_q;
      if (s2.val && s2.sof) cfg_c = s2.cfg;
      r3_c      = '0;
      r3_c.val  = s2.val;
      r3_c.raw  = (s2_luma >= cfg_c.thr) ^ cfg_c.inv;
      r3_c.filt = cfg_c.filt;
      r3_c.x    = s2.x;
      r3_c.y    = s2.y;
   end

   // Stages 3-4: threshold register doubles as the right slot of the window.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cfg_q <= CFG_RST;
         r3    <= '0;
         w_c   <= '0;
         w_l   <= '0;
      end else begin
         cfg_q <= cfg_c;
         r3    <= r3_c;
         w_c   <= r3;
         w_l   <= '{val: w_c.val, raw: w_c.raw, y: w_c.y};
      end
   end

   always_comb begin
      nb_l_c = w_l.val && w_l.raw && (w_l.y == w_c.y) && (w_c.x != '0);
      nb_r_c = r3.val && r3.raw && (r3.y == w_c.y) && (w_c.x != X_LAST);
      filt_c = w_c.raw;
      if (w_c.filt) filt_c = (nb_l_c & w_c.raw) | (w_c.raw & nb_r_c) | (nb_l_c & nb_r_c);
   end

   // Stages 5-6: filtered result, then output register that holds through gaps.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         f5        <= '0;
         oMASK_VAL <= 1'b0;
         oMASK     <= 1'b0;
         oMASK_X   <= '0;
         oMASK_Y   <= '0;
      end else begin
         f5        <= '{val: w_c.val, mask: filt_c, x: w_c.x, y: w_c.y};
         oMASK_VAL <= f5.val;
         if (f5.val) begin
            oMASK   <= f5.mask;
            oMASK_X <= f5.x;
            oMASK_Y <= f5.y;
         end
      end
   end

   always_comb begin
      sof_out_c = oMASK_VAL && (oMASK_X == '0) && (oMASK_Y == '0);
      eof_out_c = oMASK_VAL && (oMASK_X == X_LAST) && (oMASK_Y == Y_LAST);
   end

   // Only a frame seen from its first pixel is reported.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         acc      <= '0;
         started  <= 1'b0;
         oCNT     <= '0;
         oCNT_VAL <= 1'b0;
      end else begin
         oCNT_VAL <= 1'b0;
         if (eof_out_c) begin
            acc     <= '0;
            started <= 1'b0;
            if (started) begin
               oCNT     <= acc + CNT_W'(oMASK);
               oCNT_VAL <= 1'b1;
            end
         end else if (sof_out_c) begin
            acc     <= CNT_W'(oMASK);
            started <= 1'b1;
         end else if (oMASK_VAL && oMASK) begin
            acc <= acc + CNT_W'(1);
         end
      end
   end

endmodule
